// File: rtl/nvdla_glb_csb_pkg.sv
// rtl/nvdla_glb_csb_pkg.sv - CSB request/response field layout shared by the GLB CSB slave
package nvdla_glb_csb_pkg;

  localparam int REQ_W           = 63;
  localparam int REQ_ADDR_LSB    = 0;
  localparam int REQ_ADDR_W      = 22;
  localparam int REQ_WDAT_LSB    = 22;
  localparam int REQ_WDAT_W      = 32;
  localparam int REQ_WRITE_BIT   = 54;
  localparam int REQ_NPOSTED_BIT = 55;
  localparam int REQ_SRCPRIV_BIT = 56;
  localparam int REQ_WRBE_LSB    = 57;
  localparam int REQ_WRBE_W      = 4;
  localparam int REQ_LEVEL_LSB   = 61;
  localparam int REQ_LEVEL_W     = 2;

  localparam int RESP_W      = 34;
  localparam int RESP_RDAT_W = 32;

  localparam logic RESP_TYPE_RD = 1'b0;
  localparam logic RESP_TYPE_WR = 1'b1;

endpackage

// File: rtl/nvdla_glb_resp_pipe.sv
// rtl/nvdla_glb_resp_pipe.sv - LAT-stage valid+data response delay line, async active-low reset
module nvdla_glb_resp_pipe #(
  parameter int LAT = 1,
  parameter int W   = 34
) (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         i_valid,
  input  logic [W-1:0] i_pd,
  output logic         o_valid,
  output logic [W-1:0] o_pd
);

  logic [LAT-1:0] r_vld;
  logic [W-1:0]   r_pd [LAT];

  // Data only advances alongside a valid entry, so the output holds its last response on bubbles.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) r_pd[i] <= '0;
    end else begin
      r_vld[0] <= i_valid;
      if (i_valid) r_pd[0] <= i_pd;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign o_valid = r_vld[LAT-1];
  assign o_pd    = r_pd[LAT-1];

endmodule

// File: rtl/nvdla_glb_csb_regs.sv
// rtl/nvdla_glb_csb_regs.sv - GLB CSB slave register file; NVDLA_GLB_CSB_REGS_ACC_CNT_EN adds an access counter
module nvdla_glb_csb_regs
  import nvdla_glb_csb_pkg::*;
#(
  parameter logic [21:0] BASE_ADDR = 22'h0,
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] ID_VALUE  = 32'h0000_0001,
  parameter int          RESP_LAT  = 1
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              csb2gec_req_pvld,
  output logic              csb2gec_req_prdy,
  input  logic [REQ_W-1:0]  csb2gec_req_pd,
  output logic              gec2csb_resp_valid,
  output logic [RESP_W-1:0] gec2csb_resp_pd
);

  logic [REQ_ADDR_W-1:0] w_addr;
  logic [REQ_WDAT_W-1:0] w_wdat;
  logic [REQ_WRBE_W-1:0] w_wrbe;
  logic                  w_write;
  logic                  w_nposted;
  logic                  w_unused_fields;
  logic [REQ_ADDR_W-1:0] w_idx;
  logic                  w_above;
  logic                  w_reg_hit;
  logic                  w_wr_acc;
  logic [31:0]           w_rdat;
  logic                  w_err;
  logic                  w_resp_vld;
  logic [RESP_W-1:0]     w_resp_pd;
  logic [31:0]           r_regs [1:NUM_REGS-1];

  assign w_addr          = csb2gec_req_pd[REQ_ADDR_LSB +: REQ_ADDR_W];
  assign w_wdat          = csb2gec_req_pd[REQ_WDAT_LSB +: REQ_WDAT_W];
  assign w_wrbe          = csb2gec_req_pd[REQ_WRBE_LSB +: REQ_WRBE_W];
  assign w_write         = csb2gec_req_pd[REQ_WRITE_BIT];
  assign w_nposted       = csb2gec_req_pd[REQ_NPOSTED_BIT];
  assign w_unused_fields = ^{csb2gec_req_pd[REQ_SRCPRIV_BIT], csb2gec_req_pd[REQ_LEVEL_LSB +: REQ_LEVEL_W]};

  assign csb2gec_req_prdy = 1'b1;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range; w_above guards it explicitly.
  assign w_idx     = w_addr - BASE_ADDR;
  assign w_above   = (w_addr >= BASE_ADDR);
  assign w_reg_hit = w_above && (w_idx < REQ_ADDR_W'(NUM_REGS));
  assign w_wr_acc  = csb2gec_req_pvld && w_write;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_acc && w_reg_hit) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        for (int k = 0; k < REQ_WRBE_W; k++) begin
          if (w_idx == REQ_ADDR_W'(i) && w_wrbe[k]) r_regs[i][8*k +: 8] <= w_wdat[8*k +: 8];
        end
      end
    end
  end

`ifdef NVDLA_GLB_CSB_REGS_ACC_CNT_EN
  logic        w_cnt_hit;
  logic [31:0] r_acc_cnt;

  assign w_cnt_hit = w_above && (w_idx == REQ_ADDR_W'(NUM_REGS));

  // A write to the counter clears it and replaces that request's own increment.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_acc_cnt <= '0;
    end else if (csb2gec_req_pvld) begin
      if (w_write && w_cnt_hit) r_acc_cnt <= '0;
      else if (r_acc_cnt != 32'hFFFF_FFFF) r_acc_cnt <= r_acc_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    w_rdat = '0;
    w_err  = 1'b1;
    if (w_reg_hit) begin
      w_err = w_write && (w_idx == '0);
      if (w_idx == '0) w_rdat = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_idx == REQ_ADDR_W'(i)) w_rdat = r_regs[i];
      end
    end
`ifdef NVDLA_GLB_CSB_REGS_ACC_CNT_EN
    else if (w_cnt_hit) begin
      w_err  = 1'b0;
      w_rdat = r_acc_cnt;
    end
`endif
  end

  assign w_resp_vld = csb2gec_req_pvld && (!w_write || w_nposted);
  assign w_resp_pd  = {(w_write ? RESP_TYPE_WR : RESP_TYPE_RD), w_err,
                       (w_write ? {RESP_RDAT_W{1'b0}} : w_rdat)};

  nvdla_glb_resp_pipe #(
    .LAT (RESP_LAT),
    .W   (RESP_W)
  ) u_resp_pipe (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .i_valid         (w_resp_vld),
    .i_pd            (w_resp_pd),
    .o_valid         (gec2csb_resp_valid),
    .o_pd            (gec2csb_resp_pd)
  );

endmodule
